// File: rtl/regfile_sync.sv
// regfile_sync: parametrised 2-read/1-write register file.
// Hardwired zero entry, write-to-read bypass, clear sweep after reset.
module regfile_sync #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rd_valid,
    output logic              wr_done,
    output logic              ready
);

    localparam logic [0:0] S_CLEAR = 1'b0;
    localparam logic [0:0] S_RUN   = 1'b1;

    // Extra counter bit lets DEPTH == 2**ADDR_W be represented.
    localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST_C  = DEPTH_C - 1'b1;

    logic [0:0]        r_state;
    logic [ADDR_W:0]   r_cnt;
    logic              r_ready;
    logic              r_rd_valid;
    logic              r_wr_done;
    logic [DATA_W-1:0] r_rs1;
    logic [DATA_W-1:0] r_rs2;

    // Storage spans the full address space so any address indexes safely;
    // entries at or above DEPTH are never written nor returned.
    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

    logic              w_run;
    logic              w_wr_ok;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] w_rs1;
    logic [DATA_W-1:0] w_rs2;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    function automatic logic f_is_zero(input logic [ADDR_W-1:0] a);
        return ZERO_REG && (a == '0);
    endfunction

    // Read value seen at this edge, with optional forwarding of a live write.
    function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (f_in_range(a) && !f_is_zero(a)) begin
            if (BYPASS && w_wr_ok && (wr_addr == a)) v = wr_data;
            else                                      v = r_mem[a];
        end
        return v;
    endfunction

    assign w_run   = (r_state == S_RUN);
    assign w_wr_ok = w_run && wr_en && f_in_range(wr_addr) && !f_is_zero(wr_addr);

    // Select the single memory write: sweep zeroing or a committed write.
    always_comb begin
        w_mem_we   = 1'b0;
        w_mem_addr = wr_addr;
        w_mem_data = wr_data;
        if (!rst) begin
            if (!w_run) begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_cnt[ADDR_W-1:0];
                w_mem_data = '0;
            end else if (w_wr_ok) begin
                w_mem_we   = 1'b1;
            end
        end
    end

    // Read data for both ports, evaluated independently.
    always_comb begin
        w_rs1 = f_read(rs1_addr);
        w_rs2 = f_read(rs2_addr);
    end

    // Storage array; reset deliberately leaves contents alone.
    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_mem_addr] <= w_mem_data;
    end

    // Sweep FSM, handshake pulses and registered read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_CLEAR;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
        end else if (!w_run) begin
            r_rd_valid <= 1'b0;
            r_wr_done  <= 1'b0;
            r_cnt      <= r_cnt + 1'b1;
            if (r_cnt == LAST_C) begin
                r_state <= S_RUN;
                r_ready <= 1'b1;
            end
        end else begin
            r_wr_done  <= wr_en;
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rs1 <= w_rs1;
                r_rs2 <= w_rs2;
            end
        end
    end

    assign rs1_data = r_rs1;
    assign rs2_data = r_rs2;
    assign rd_valid = r_rd_valid;
    assign wr_done  = r_wr_done;
    assign ready    = r_ready;

endmodule

// File: tb/tb_regfile_sync.sv
// tb_regfile_sync: two register-file instances (bypass/32 deep and
// no-bypass/20 deep) checked every cycle against an array model.
module tb_regfile_sync;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_q [2];
    logic [31:0] rs2_q [2];
    logic        vld_q [2];
    logic        done_q [2];
    logic        rdy_q [2];

    int n_chk  = 0;
    int n_pass = 0;

    localparam int DEP [2] = '{32, 20};
    localparam bit BYP [2] = '{1'b1, 1'b0};

    logic [31:0] m_mem [2][32];
    int          m_sweep [2];
    logic [31:0] e_rs1 [2];
    logic [31:0] e_rs2 [2];

    always #5 clk = ~clk;

    regfile_sync u0 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_q[0]), .rs2_data(rs2_q[0]),
        .rd_valid(vld_q[0]), .wr_done(done_q[0]), .ready(rdy_q[0])
    );

    regfile_sync #(.DEPTH(20), .BYPASS(1'b0)) u1 (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_en(rd_en), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .rs1_data(rs1_q[1]), .rs2_data(rs2_q[1]),
        .rd_valid(vld_q[1]), .wr_done(done_q[1]), .ready(rdy_q[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdref(input int k, input logic [4:0] a);
        if (a == 0 || int'(a) >= DEP[k]) return 32'h0;
        if (BYP[k] && wr_en && wr_addr == a) return wr_data;
        return m_mem[k][a];
    endfunction

    // One clock: predict from current inputs, advance, compare all outputs.
    task automatic tick(input string tag);
        bit e_vld [2];
        bit e_done [2];
        bit e_rdy [2];
        for (int k = 0; k < 2; k++) begin
            e_vld[k]  = 1'b0;
            e_done[k] = 1'b0;
            if (rst) begin
                m_sweep[k] = 0;
                e_rs1[k]   = 32'h0;
                e_rs2[k]   = 32'h0;
            end else if (m_sweep[k] < DEP[k]) begin
                m_mem[k][m_sweep[k]] = 32'h0;
                m_sweep[k]++;
            end else begin
                e_vld[k]  = rd_en;
                e_done[k] = wr_en;
                if (rd_en) begin
                    e_rs1[k] = rdref(k, rs1_addr);
                    e_rs2[k] = rdref(k, rs2_addr);
                end
                if (wr_en && wr_addr != 0 && int'(wr_addr) < DEP[k])
                    m_mem[k][wr_addr] = wr_data;
            end
            e_rdy[k] = (m_sweep[k] == DEP[k]);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s.u%0d.ready", tag, k), 32'(rdy_q[k]), 32'(e_rdy[k]));
            chk($sformatf("%s.u%0d.rd_valid", tag, k), 32'(vld_q[k]), 32'(e_vld[k]));
            chk($sformatf("%s.u%0d.wr_done", tag, k), 32'(done_q[k]), 32'(e_done[k]));
            chk($sformatf("%s.u%0d.rs1", tag, k), rs1_q[k], e_rs1[k]);
            chk($sformatf("%s.u%0d.rs2", tag, k), rs2_q[k], e_rs2[k]);
        end
    endtask

    task automatic drive(input string tag, input bit we, input logic [4:0] wa,
                         input logic [31:0] wd, input bit re,
                         input logic [4:0] a1, input logic [4:0] a2);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rd_en    = re;
        rs1_addr = a1;
        rs2_addr = a2;
        tick(tag);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_sweep[k] = 0;
            e_rs1[k]   = 32'h0;
            e_rs2[k]   = 32'h0;
        end
        rst = 1'b1;
        drive("rst0", 0, 0, 0, 0, 0, 0);
        drive("rst1", 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++)
            drive("sweep", i < 5, 5'd3, 32'hCAFEF00D, i < 5, 5'd3, 5'd3);

        for (int a = 0; a < 32; a++) begin
            drive("rdall", 0, 0, 0, 1, 5'(a), 5'(31 - a));
            drive("rdall_idle", 0, 0, 0, 0, 0, 0);
        end

        drive("wr5", 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
        drive("wr31", 1, 5'd31, 32'h12345678, 0, 0, 0);
        drive("rd5_31", 0, 0, 0, 1, 5'd5, 5'd31);

        drive("wr0", 1, 5'd0, 32'hFFFFFFFF, 0, 0, 0);
        drive("rd0", 0, 0, 0, 1, 5'd0, 5'd0);

        drive("wr7a", 1, 5'd7, 32'h11111111, 0, 0, 0);
        drive("byp", 1, 5'd7, 32'hA5A5A5A5, 1, 5'd7, 5'd7);
        drive("byp_next", 0, 0, 0, 1, 5'd7, 5'd3);

        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive("rand", 1'($urandom), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)));
        end
        rst = 1'b0;
        for (int i = 0; i < 34; i++)
            drive("settle", 0, 0, 0, 0, 0, 0);

        drive("wr9", 1, 5'd9, 32'h55AA55AA, 0, 0, 0);
        drive("rd9", 0, 0, 0, 1, 5'd9, 5'd9);
        rst = 1'b1;
        drive("rst_rd", 0, 0, 0, 1, 5'd9, 5'd9);
        rst = 1'b0;
        for (int i = 0; i < 32; i++)
            drive("resweep", 0, 0, 0, 0, 0, 0);
        drive("rd9_clr", 0, 0, 0, 1, 5'd9, 5'd5);
        drive("end", 0, 0, 0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_sync.md
Name: regfile_sync

Overview:
- Parametrised synchronous register file; successor to the single-bit 4-entry storage cell.
- Adds multi-bit width, configurable depth, two read ports and one write port.
- Adds hardwired zero register, write-to-read bypass, and a sequential clear-on-reset sweep.
- Sits in the RISC-V datapath between decode (rs1/rs2/rd addresses) and execute/writeback.

Parameters:
- DATA_W, 32, width of each entry in bits.
- DEPTH, 32, number of entries; 2..2**ADDR_W.
- ADDR_W, 5, address width.
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes.
- BYPASS, 1, 1 = a same-cycle write to a read address forwards the new data.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- wr_en  input  1  write request.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_en  input  1  read request for both ports.
- rs1_addr  input  ADDR_W  read port 1 address.
- rs2_addr  input  ADDR_W  read port 2 address.
- rs1_data  output  DATA_W  read port 1 data, registered.
- rs2_data  output  DATA_W  read port 2 data, registered.
- rd_valid  output  1  one-cycle pulse: rs1_data and rs2_data are valid.
- wr_done  output  1  one-cycle pulse: the write was committed.
- ready  output  1  high once the clear sweep is complete.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.

Reset:
- On a clk edge with rst=1: rs1_data=0, rs2_data=0, rd_valid=0, wr_done=0, ready=0.
- Same edge: clear counter=0, FSM enters CLEAR.
- Entry contents are not touched by the rst edge itself.

FSM states and transitions:
- CLEAR:
  - Each cycle, write 0 to entry[counter], then counter++.
  - When counter==DEPTH-1 is written, go to RUN and set ready=1 on the same edge.
  - Sweep takes exactly DEPTH cycles after rst falls.
  - wr_en and rd_en are ignored: no write, no read; rd_valid and wr_done stay 0.
- RUN: normal operation; stays in RUN until rst.
- Reset mid-sweep or mid-operation: returns to CLEAR with counter=0. In-flight rd_valid/wr_done are not asserted on the following cycle.

Write (RUN only):
- wr_en=1 at an edge stores wr_data into entry[wr_addr].
- wr_done=1 the following cycle, otherwise 0.
- Writes with ZERO_REG=1 and wr_addr==0: discarded, but wr_done still pulses.
- Writes with wr_addr>=DEPTH: discarded, but wr_done still pulses.

Read (RUN only):
- rd_en=1 at edge N: rs1_data and rs2_data are loaded at edge N, rd_valid=1 for the cycle after edge N. Latency is 1 cycle.
- rd_en=0: data outputs hold their last value; rd_valid=0.
- Read of address 0 with ZERO_REG=1, or of address >=DEPTH, returns 0.

Simultaneous write and read at the same edge:
- If the read address equals wr_addr and that write is not discarded:
  - BYPASS=1: returns wr_data.
  - BYPASS=0: returns the old content.
- Both ports are evaluated independently; rs1_addr==rs2_addr is legal and both ports return the same value.

Back-to-back operation:
- rd_en and wr_en may be asserted every cycle with no stall.
- Full throughput: 1 write + 2 reads per cycle.

Width rules:
- No arithmetic on data.
- Counter is ADDR_W+1 bits so DEPTH=2**ADDR_W terminates correctly.

Test Plan:
- Reset sweep: rst high 2 cycles then low, DEPTH=32 -> ready rises exactly 32 cycles later; read of every address returns 0x00000000 with rd_valid pulsing 1 cycle after each rd_en.
- Write/readback: write 0xDEADBEEF to 5 and 0x12345678 to 31 → wr_done pulses; read rs1=5, rs2=31 → next cycle rs1_data=0xDEADBEEF, rs2_data=0x12345678, rd_valid=1.
- Zero register: write 0xFFFFFFFF to 0 → wr_done=1; read rs1=0, rs2=0 → both return 0.
- Bypass:
  - Same edge: write 0xA5A5A5A5 to 7 and read rs1=7 while entry 7 holds 0x11111111.
  - BYPASS=1 → rs1_data=0xA5A5A5A5.
  - BYPASS=0 → rs1_data=0x11111111, and a read the next cycle returns 0xA5A5A5A5.
- Ignored requests in CLEAR: assert wr_en (addr 3, 0xCAFEF00D) and rd_en during the sweep → no wr_done or rd_valid; after ready, entry 3 reads 0.
- Reset mid-operation: load entry 9 with 0x55AA55AA, assert rd_en and rst on the same edge → rd_valid stays 0, ready drops, sweep reruns; after ready, entry 9 reads 0.
